// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant.
// Grant is held until release, or preempted after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       any_req
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HL);

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      grant_q, grant_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;

  logic [2:0]      scan_idx;
  logic [2:0]      pick_idx;
  logic            pick_found;
  logic            release_now;
  logic            preempt_now;

  assign any_req = |req;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Owner drops its request, or has used its slot while others wait.
  always_comb begin
    release_now = !req[owner_q];
    preempt_now = (MAX_HOLD != 0)
               && (hold_cnt_q == HOLD_LAST)
               && (|(req & ~grant_q));
  end

  // Next-state and next-output selection.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANT;
          owner_d       = pick_idx;
          grant_d       = 8'b1 << pick_idx;
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      GRANT: begin
        if (release_now || preempt_now) begin
          state_d       = IDLE;
          ptr_d         = owner_q + 3'd1;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed table, reset corner,
// and random traffic against a behavioural model.
module tb_rr_arbiter8;

  localparam int MH    = 4;
  localparam int BOUND = 8 * (MH + 1);

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       any_req;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .any_req     (any_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] id;
  } vec_t;

  vec_t tbl[$];

  // behavioural model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;

  int rem[8];
  int wt[8];

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endtask

  function automatic void add(input logic [7:0] r,
                              input logic [7:0] g,
                              input logic [2:0] id);
    vec_t v;
    v.r = r;
    v.g = g;
    v.id = id;
    tbl.push_back(v);
  endfunction

  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_init();
    m_busy = 0;
    m_owner = 0;
    m_ptr = 0;
    m_hold = 0;
  endfunction

  // One arbitration decision from the sampled request vector.
  function automatic void model_step(input logic [7:0] r);
    logic [7:0] others;
    int j;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!m_busy && r[j]) begin
          m_busy = 1;
          m_owner = j;
          m_hold = 0;
        end
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] ||
          (MH != 0 && m_hold == MH - 1 && others != 0)) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 8;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endfunction

  initial begin
    logic [7:0] eg;
    logic       idok;
    int         maxw;

    reset = 1'b1;
    req   = 8'h00;
    model_init();
    #3;
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", {7'b0, grant_valid}, 8'h00);
    chk("rst_id", {5'b0, grant_id}, 8'h00);
    chk("rst_anyreq", {7'b0, any_req}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle
    for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 3'd0);
    // two requesters, release, bubble, next
    add(8'h81, 8'h01, 3'd0);
    add(8'h81, 8'h01, 3'd0);
    add(8'h80, 8'h00, 3'd0);
    add(8'h80, 8'h80, 3'd7);
    add(8'h80, 8'h80, 3'd7);
    add(8'h00, 8'h00, 3'd0);
    // client 6 leaves ptr at 7, scan wraps to 1
    add(8'h40, 8'h40, 3'd6);
    add(8'h00, 8'h00, 3'd0);
    add(8'h42, 8'h02, 3'd1);
    add(8'h00, 8'h00, 3'd0);
    // preemption after exactly MH cycles, both ways
    add(8'h04, 8'h04, 3'd2);
    add(8'h24, 8'h04, 3'd2);
    add(8'h24, 8'h04, 3'd2);
    add(8'h24, 8'h04, 3'd2);
    add(8'h24, 8'h00, 3'd0);
    add(8'h24, 8'h20, 3'd5);
    add(8'h24, 8'h20, 3'd5);
    add(8'h24, 8'h20, 3'd5);
    add(8'h24, 8'h20, 3'd5);
    add(8'h24, 8'h00, 3'd0);
    add(8'h24, 8'h04, 3'd2);
    add(8'h00, 8'h00, 3'd0);
    // lone owner never preempted
    for (int i = 0; i < 21; i++) add(8'h08, 8'h08, 3'd3);
    add(8'h00, 8'h00, 3'd0);
    add(8'h20, 8'h20, 3'd5);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
      chk($sformatf("tbl%0d_id", i), {5'b0, grant_id},
          {5'b0, tbl[i].id});
      chk($sformatf("tbl%0d_valid", i), {7'b0, grant_valid},
          {7'b0, tbl[i].g != 0});
      chk($sformatf("tbl%0d_anyreq", i), {7'b0, any_req},
          {7'b0, tbl[i].r != 0});
    end

    // async reset between edges while client 5 owns
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_grant", grant, 8'h00);
    chk("midrst_valid", {7'b0, grant_valid}, 8'h00);
    chk("midrst_id", {5'b0, grant_id}, 8'h00);
    chk("midrst_anyreq", {7'b0, any_req}, 8'h01);
    #1;
    reset = 1'b0;
    cycle(8'h21);
    chk("postrst_grant", grant, 8'h01);
    chk("postrst_id", {5'b0, grant_id}, 8'h00);

    // random traffic
    req = 8'h00;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_init();
    for (int i = 0; i < 8; i++) begin
      rem[i] = 0;
      wt[i] = 0;
    end

    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      model_step(req);
      #1;
      eg = '0;
      if (m_busy) eg[m_owner] = 1'b1;
      chk("rnd_grant", grant, eg);
      chk("rnd_onehot", {7'b0, $onehot0(grant)}, 8'h01);
      chk("rnd_valid", {7'b0, grant_valid}, {7'b0, |grant});
      idok = grant_valid ? grant[grant_id] : (grant_id == 3'd0);
      chk("rnd_idmatch", {7'b0, idok}, 8'h01);
      chk("rnd_anyreq", {7'b0, any_req}, {7'b0, |req});
      maxw = 0;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !(m_busy && m_owner == i)) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > maxw) maxw = wt[i];
      end
      chk("rnd_starve", {7'b0, maxw > BOUND}, 8'h00);
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (m_busy && m_owner == i) begin
            rem[i]--;
            if (rem[i] <= 0) req[i] = 1'b0;
          end
        end else if ($urandom_range(3) == 0) begin
          req[i] = 1'b1;
          rem[i] = $urandom_range(8, 1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one downstream resource (bus, ALU port, memory port) between up to eight clients.
- Uses 8-way OR reduction of the request vector to detect pending work, then issues a registered one-hot grant.
- Each grant is held until the requester releases it, or until a hold-time limit expires while others are waiting.
- Sits between client request lines and the shared-resource mux select.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT-state cycles for one owner while another requester waits; 0 disables preemption.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  8  request vector, bit i = client i wants the resource; level-sensitive, held until done
- grant  output  8  registered one-hot grant, all-zero when idle
- grant_id  output  3  binary index of current owner; 0 when grant_valid=0
- grant_valid  output  1  registered, equals |grant
- any_req  output  1  combinational |req (8-way OR), no register

Behaviour:
- One clock, clk. Asynchronous, active-high reset on reset: grant=0, grant_id=0, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE. Takes effect immediately, not at the next edge.
- State: 3-bit ptr (highest-priority index), 3-bit owner, hold counter sized for MAX_HOLD, FSM {IDLE, GRANT}.
- IDLE:
  - If req != 0 at a rising edge, select the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7 mod 8 (wrap-around).
  - Set grant=1<<i, grant_id=i, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency: grant is visible 1 cycle after req is sampled high.
  - If req==0, remain in IDLE with outputs zero.
- GRANT, evaluated each rising edge in this priority order:
  1. Release: if req[owner]=0, then grant=0, grant_valid=0, grant_id=0, ptr=(owner+1) mod 8, state=IDLE.
  2. Preempt: else if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~grant)!=0, then apply the same release actions. The owner therefore holds for exactly MAX_HOLD cycles.
  3. Hold: else keep grant. hold_cnt increments and saturates at MAX_HOLD-1.
- Requests from non-owners never alter grant during GRANT, except through the preemption rule.
- Any release is followed by a mandatory 1-cycle bubble (grant_valid=0 for one cycle). A new grant can be issued on the next edge.
- A preempted owner that keeps req high competes normally. It has lowest priority because ptr has advanced past it.
- If the owner is alone and keeps requesting, hold_cnt saturates and there is no preemption. The grant is held indefinitely.
- Exactly one grant bit is ever set. grant, grant_id, and grant_valid are mutually consistent on every cycle.
- Reset asserted mid-grant: outputs drop to zero asynchronously, and ptr returns to 0, so client 0 has top priority after reset.
- req bits that toggle between edges are ignored. Only edge-sampled values matter.
- any_req follows req combinationally in all states, including during reset.

Test Plan:
- Reset then req=8'b0000_0000 for 5 cycles -> grant=0, grant_valid=0, grant_id=0, any_req=0 throughout.
- After reset, req=8'b1000_0001 held -> 1 cycle later grant=8'b0000_0001, id=0. Drop req[0] -> next edge grant=0 (bubble), following edge grant=8'b1000_0000, id=7.
- Wrap-around: ptr at 7 (client 6 just released), req=8'b0100_0010 -> grant=8'b0000_0010, id=1 (client 7 absent, scan wraps to 0 then 1).
- Preemption, MAX_HOLD=4: client 2 granted, then req=8'b0010_0100 held -> grant[2] high exactly 4 cycles, 1 bubble, then grant=8'b0010_0000. Client 2 is re-granted only after client 5 releases.
- Lone owner, MAX_HOLD=4: req=8'b0000_1000 held for 20 cycles -> grant=8'b0000_1000 for all cycles after the first, no bubble.
- Reset pulsed mid-grant (id=5), between clock edges -> grant=0 before the next clk edge. After release of reset with req=8'b0010_0001 -> grant=8'b0000_0001 (ptr back at 0).
- Random: 10000 cycles of $random req, each held until granted plus random release delay. Check every cycle: one-hot grant, grant_valid==|grant, grant_id matches grant, no starvation (each waiting requester granted within 8*(MAX_HOLD+1) cycles), any_req==|req.
